// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide unit
//
// Purpose: operation codes, default latency constants and FSM state encoding
// used by muldiv_unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: executes MULT/MULTU/DIV/DIVU with a fixed, counter-modelled latency
// and holds the architectural HI/LO registers (also written by MTHI/MTLO).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   start  in   launch op with operands a, b (ignored while busy)
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   a, b   in   rs / rt operands (sampled only at the start edge)
//   mthi   in   write a into HI (idle only, loses to start)
//   mtlo   in   write a into LO (idle only, loses to start)
//   busy   out  operation in flight (registered)
//   hi, lo out  HI / LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [31:0]   r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
  logic          r_pend_wr, w_pend_wr_nxt;

  // Result datapath: both operands widened to 33 bits so one signed
  // operator set covers signed and unsigned forms alike.
  logic               w_is_div, w_signed, w_b_zero;
  logic signed [32:0] w_a_ext, w_b_ext, w_div_b, w_quo, w_rem;
  logic signed [65:0] w_a_wide, w_b_wide, w_prod;
  logic [31:0]        w_res_hi, w_res_lo;
  logic               w_unused_bits;

  assign w_is_div = op[1];
  assign w_signed = ~op[0];
  assign w_a_ext  = {w_signed & a[31], a};
  assign w_b_ext  = {w_signed & b[31], b};
  assign w_b_zero = (b == 32'd0);
  // Substitute divisor keeps the divider defined on b==0; the result is
  // discarded in that case anyway.
  assign w_div_b  = w_b_zero ? 33'sd1 : w_b_ext;

  assign w_a_wide = {{33{w_a_ext[32]}}, w_a_ext};
  assign w_b_wide = {{33{w_b_ext[32]}}, w_b_ext};
  assign w_prod   = w_a_wide * w_b_wide;
  assign w_quo    = w_a_ext / w_div_b;
  assign w_rem    = w_a_ext % w_div_b;

  assign w_res_hi = w_is_div ? w_rem[31:0] : w_prod[63:32];
  assign w_res_lo = w_is_div ? w_quo[31:0] : w_prod[31:0];

  assign w_unused_bits = ^{w_prod[65:64], w_quo[32], w_rem[32]};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_wr_nxt = r_pend_wr;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = w_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          w_pend_hi_nxt = w_res_hi;
          w_pend_lo_nxt = w_res_lo;
          w_pend_wr_nxt = ~(w_is_div & w_b_zero);
        end else begin
          if (mthi) w_hi_nxt = a;
          if (mtlo) w_lo_nxt = a;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
          if (r_pend_wr) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation, from the instruction definitions.
  task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sp, sx, sy, sq, sr;
    longint unsigned up;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      2'd2: if (y != 0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sq = sx / sy;
        sr = sx % sy;
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      default: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
    endcase
  endtask

  // Launch at the current (post-edge) point, then scramble the operands and
  // measure how long busy stays high; a move asserted alongside start is dropped.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit with_move);
    int cnt;
    start = 1'b1; op = o; a = x; b = y; mthi = with_move; mtlo = with_move;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom;
    model_op(o, x, y);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, 32'(cnt), (o[1] ? 32'd10 : 32'd5));
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic do_move(input bit h, input bit l, input logic [31:0] x);
    mthi = h; mtlo = l; a = x;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = x;
    if (l) m_lo = x;
    check("move_hi", hi, m_hi);
    check("move_lo", lo, m_lo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int cnt;

    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Directed arithmetic cases
    run_op("mult_neg1x2", 2'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_neg1x2_const_hi", hi, 32'hFFFFFFFF);
    check("mult_neg1x2_const_lo", lo, 32'hFFFFFFFE);
    run_op("multu_ffx2", 2'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_const_hi", hi, 32'h00000001);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
    check("divu_const_lo", lo, 32'd14);
    check("divu_const_hi", hi, 32'd2);
    run_op("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_m7_2_const_lo", lo, 32'hFFFFFFFD);
    run_op("div_min_m1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_min_m1_const_lo", lo, 32'h80000000);
    check("div_min_m1_const_hi", hi, 32'd0);

    // Move then divide by zero leaves HI/LO untouched
    do_move(1'b1, 1'b0, 32'h12345678);
    run_op("divu_by0", 2'd3, 32'd5, 32'd0, 1'b0);
    check("divu_by0_const_hi", hi, 32'h12345678);
    run_op("div_by0", 2'd2, 32'hFFFF0000, 32'd0, 1'b0);

    // Start and move together: start wins
    run_op("start_vs_move", 2'd0, 32'd6, 32'd7, 1'b1);

    // Start/mtlo while busy are ignored
    start = 1'b1; op = 2'd1; a = 32'h0001_0003; b = 32'h0002_0005;
    @(posedge clk); #1;
    start = 1'b0;
    model_op(2'd1, 32'h0001_0003, 32'h0002_0005);
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0; a = 32'hDEAD; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    cnt = 3;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("busy_ignore_cycles", 32'(cnt), 32'd5);
    check("busy_ignore_hi", hi, m_hi);
    check("busy_ignore_lo", lo, m_lo);
    @(posedge clk); #1;
    check("busy_ignore_no_restart", {31'd0, busy}, 32'd0);

    // Reset in the middle of a divide
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("midreset_no_late_hi", hi, 32'd0);
    check("midreset_no_late_lo", lo, 32'd0);
    run_op("mult_3x4", 2'd0, 32'd3, 32'd4, 1'b0);
    check("mult_3x4_const_lo", lo, 32'd12);

    // Randomized operations interleaved with moves
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 4) == 0)
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op("rand", ro, ra, rb, 1'($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
